mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous memory between two requesters:
  - the multicycle CPU memory port (instruction fetch plus load/store);
  - a debug/program-loader port.
- Sits between the multicycle datapath's memory-address mux and the unified memory.
- Serialises accesses with a req/gnt/rvalid handshake and owns all memory control signals.
- Exactly one access is in flight at a time.

Parameters:
- AW, 32, address width in bits (byte address, passed through unmodified).
- DW, 32, data width in bits.
- MEM_LAT, 1, memory read latency in cycles from mem_en to valid mem_rdata. Legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset: state clears whenever reset==0.
- cpu_req  in  1  CPU access request; held until cpu_gnt.
- cpu_we  in  1  CPU write enable.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_gnt  out  1  CPU request accepted this cycle.
- cpu_rvalid  out  1  one-cycle completion pulse for the CPU access (read data or write ack).
- cpu_rdata  out  DW  CPU read data, valid while cpu_rvalid==1.
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/AW/DW  debug port; same meaning as the CPU equivalents.
- dbg_gnt, dbg_rvalid  out  1  debug port; same meaning as the CPU equivalents.
- dbg_rdata  out  DW  debug port; same meaning as cpu_rdata.
- mem_en  out  1  memory access strobe, one cycle per access.
- mem_we  out  1  memory write enable, qualified by mem_en.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after mem_en.

Behaviour:
- Reset values: state=ArbIdle, all gnt/rvalid/mem_en/mem_we=0, all addr/data registers=0, rr pointer=OwnDbg (so the CPU wins the first contention).
- ArbIdle:
  - If any req is high, the winner's gnt=1 combinationally in the same cycle.
  - Latch the winner's we/addr/wdata and owner; go to ArbIssue.
  - No req: stay in ArbIdle.
  - gnt is never asserted outside ArbIdle.
- ArbIssue (1 cycle):
  - mem_en=1; mem_we=latched we; mem_addr/mem_wdata from the latched values.
  - Load counter=MEM_LAT-1.
  - Go to ArbWait if MEM_LAT>1, else ArbResp.
- ArbWait:
  - Decrement the counter each cycle; go to ArbResp when the counter==1.
  - mem_* outputs are 0 while waiting.
- ArbResp:
  - Capture mem_rdata into the owner's rdata register.
  - Go to ArbIdle.
- Completion:
  - The owner's rvalid=1 for exactly the cycle after ArbResp, with rdata stable that cycle.
  - Writes also pulse rvalid; rdata is then don't-care, and the value is left unchanged.
  - The non-owner's rvalid stays 0.
- Latency: grant in cycle G; mem_en in G+1; rvalid in G+MEM_LAT+2.
- Next grant: the earliest is G+MEM_LAT+2, because ArbIdle is re-entered the same cycle rvalid pulses.
- Requester rule: req/we/addr/wdata must stay stable until gnt is sampled high. After gnt the requester may drop req or change its inputs; the arbiter works from latched copies.
- Requests arriving outside ArbIdle are held off, not dropped; the requester simply keeps req high.
- Simultaneous requests: resolved by the priority rule (see Optional Feature).
- Reset asserted mid-access:
  - The access is aborted immediately; no rvalid is ever produced for it.
  - mem_en drops asynchronously.
  - The memory may or may not have committed a write issued in that same cycle.
- rvalid and gnt for the same requester may be high in the same cycle; this is the back-to-back case.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: on contention, the requester that did not win the last contended grant wins.
  - The rr pointer updates only on contended grants.
  - An uncontended grant does not move the pointer.
- Undefined: fixed priority, CPU always wins over debug; the rr pointer register is not instantiated.
- Debug may then starve while the CPU is continuously requesting. This is acceptable because debug is used only with the CPU halted.

Decomposition:
- Package MemArbPkg:
  - state enum {ArbIdle, ArbIssue, ArbWait, ArbResp};
  - owner enum {OwnCpu, OwnDbg};
  - localparam CNT_W=4.
- One sub-module: mem_arb_pick.
  - Combinational winner select from cpu_req, dbg_req and the rr pointer.
  - Contains the MEM_ARB_ROUND_ROBIN_EN conditional.
  - Outputs winner and contended.

Test Plan:
- MEM_LAT=2; CPU read 0x0000_0010, memory model returns 0xDEAD_BEEF:
  - cpu_gnt at cycle 0; mem_en=1, mem_we=0, mem_addr=0x10 at cycle 1;
  - cpu_rvalid=1 with cpu_rdata=0xDEAD_BEEF at cycle 4; dbg_rvalid=0 throughout.
- Debug write 0x20 <- 0x1234_5678, MEM_LAT=1:
  - dbg_gnt cycle 0; mem_en=mem_we=1, mem_wdata=0x1234_5678 cycle 1; dbg_rvalid cycle 3;
  - a subsequent CPU read of 0x20 returns 0x1234_5678.
- Both req high at cycle 0, MEM_LAT=1, requests held:
  - fixed priority: grant order CPU, CPU, ...
  - with MEM_ARB_ROUND_ROBIN_EN: CPU at 0, debug at 3, CPU at 6.
- CPU asserts req during ArbWait of a debug access:
  - no cpu_gnt until the cycle dbg_rvalid pulses, then cpu_gnt that same cycle.
- MEM_LAT=3; reset driven to 0 in cycle 2 after a CPU grant:
  - mem_en=0 immediately; no cpu_rvalid ever appears;
  - after reset returns to 1, the first request is granted from ArbIdle normally.
- MEM_LAT=15 read:
  - rvalid exactly 17 cycles after gnt; counter wraps without an extra cycle.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, access owner, counter width.
// Pure declarations; no timing or flow-control behaviour of its own.
package MemArbPkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ArbIdle,
    ArbIssue,
    ArbWait,
    ArbResp
  } arb_state_e;

  typedef enum logic {
    OwnCpu,
    OwnDbg
  } owner_e;

  function automatic owner_e other_owner(input owner_e o);
    return (o == OwnCpu) ? OwnDbg : OwnCpu;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between CPU and debug requests; MEM_ARB_ROUND_ROBIN_EN picks round-robin.
// Purely combinational, zero latency; with no request pending the winner defaults to CPU.
module mem_arb_pick
  import MemArbPkg::*;
(
  input  logic   cpu_req,
  input  logic   dbg_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  owner_e rr_ptr,
  output logic   contended,
`endif
  output owner_e winner
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // rr_ptr holds the last contended winner, so the other side gets the next tie.
  always_comb begin
    contended = cpu_req & dbg_req;
    winner    = OwnCpu;
    if (contended) begin
      winner = other_owner(rr_ptr);
    end else if (dbg_req) begin
      winner = OwnDbg;
    end
  end
`else
  always_comb begin
    winner = OwnCpu;
    if (dbg_req && !cpu_req) begin
      winner = OwnDbg;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between CPU and debug ports; MEM_ARB_ROUND_ROBIN_EN selects arbitration.
// gnt in G, mem_en in G+1, rvalid in G+MEM_LAT+2; requests are held off (not dropped) while busy.
module mem_port_arbiter
  import MemArbPkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  arb_state_e       state_q, state_d;
  owner_e           owner_q, owner_d;
  logic             we_q, we_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cpu_rvalid_q, cpu_rvalid_d;
  logic             dbg_rvalid_q, dbg_rvalid_d;
  logic [DW-1:0]    cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0]    dbg_rdata_q, dbg_rdata_d;
  owner_e           winner;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  owner_e rr_q, rr_d;
  logic   contended;

  mem_arb_pick u_pick (
    .cpu_req   (cpu_req),
    .dbg_req   (dbg_req),
    .rr_ptr    (rr_q),
    .contended (contended),
    .winner    (winner)
  );
`else
  mem_arb_pick u_pick (
    .cpu_req (cpu_req),
    .dbg_req (dbg_req),
    .winner  (winner)
  );
`endif

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    cpu_rdata_d  = cpu_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    cpu_rvalid_d = 1'b0;
    dbg_rvalid_d = 1'b0;
    cpu_gnt      = 1'b0;
    dbg_gnt      = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    rr_d         = rr_q;
`endif

    case (state_q)
      ArbIdle: begin
        // Gated by reset so a requester never sees an acceptance while the block is held in reset.
        if (reset && (cpu_req || dbg_req)) begin
          owner_d = winner;
          state_d = ArbIssue;
          if (winner == OwnCpu) begin
            cpu_gnt = 1'b1;
            we_d    = cpu_we;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
          end else begin
            dbg_gnt = 1'b1;
            we_d    = dbg_we;
            addr_d  = dbg_addr;
            wdata_d = dbg_wdata;
          end
`ifdef MEM_ARB_ROUND_ROBIN_EN
          if (contended) begin
            rr_d = winner;
          end
`endif
        end
      end
      ArbIssue: begin
        cnt_d   = CNT_LOAD;
        state_d = (MEM_LAT > 1) ? ArbWait : ArbResp;
      end
      ArbWait: begin
        cnt_d = cnt_q - CNT_LAST;
        if (cnt_q == CNT_LAST) begin
          state_d = ArbResp;
        end
      end
      ArbResp: begin
        state_d = ArbIdle;
        if (owner_q == OwnCpu) begin
          cpu_rvalid_d = 1'b1;
          if (!we_q) cpu_rdata_d = mem_rdata;
        end else begin
          dbg_rvalid_d = 1'b1;
          if (!we_q) dbg_rdata_d = mem_rdata;
        end
      end
      default: state_d = ArbIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ArbIdle;
      owner_q      <= OwnCpu;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_q <= OwnDbg;
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

  // Memory strobes decode straight from state so an async reset drops mem_en immediately.
  assign mem_en     = (state_q == ArbIssue);
  assign mem_we     = mem_en & we_q;
  assign mem_addr   = mem_en ? addr_q : '0;
  assign mem_wdata  = mem_en ? wdata_q : '0;
  assign cpu_rvalid = cpu_rvalid_q;
  assign dbg_rvalid = dbg_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign dbg_rdata  = dbg_rdata_q;

endmodule
